// File: rtl/jk_bank_arbiter_if.sv
// Command bus shared by the two requesters of jk_bank_arbiter.
// The master side issues commands. The slave side is the arbiter, which returns the accept strobes.
interface jk_bank_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_mask;
  logic             req0_ready;
  logic             req1_valid;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_mask;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_op, req0_mask,
    output req1_valid, req1_op, req1_mask,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_mask,
    input  req1_valid, req1_op, req1_mask,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK flip-flops shared by two round-robin arbitrated requesters.
// Each requester issues masked clear/set/toggle/pulse commands.
module jk_bank_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_rst,
  jk_bank_arbiter_if.slave req,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             grant_id,
  output logic [15:0]      acc_cnt,
  output logic             err
);

  localparam logic [2:0] OpHold   = 3'b000;
  localparam logic [2:0] OpClear  = 3'b001;
  localparam logic [2:0] OpSet    = 3'b010;
  localparam logic [2:0] OpToggle = 3'b011;
  localparam logic [2:0] OpPulse  = 3'b100;

  typedef enum logic {StIdle, StPulse2} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             grant_q, grant_d;
  logic [15:0]      acc_q, acc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  logic             ready0, ready1;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] j, k;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    acc_d        = acc_q;
    err_d        = err_q;
    pulse_mask_d = pulse_mask_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    sel_op       = req.req0_op;
    sel_mask     = req.req0_mask;
    j            = '0;
    k            = '0;

    case (state_q)
      StIdle: begin
        // The rr pointer only matters when both requesters contend.
        ready0 = req.req0_valid & (~req.req1_valid | ~rr_q);
        ready1 = req.req1_valid & (~req.req0_valid | rr_q);
        if (ready1) begin
          sel_op   = req.req1_op;
          sel_mask = req.req1_mask;
        end
        if (ready0 | ready1) begin
          acc_d   = acc_q + 16'd1;
          grant_d = ready1;
          rr_d    = ~ready1;
          case (sel_op)
            OpHold: begin
            end
            OpClear: k = sel_mask;
            OpSet:   j = sel_mask;
            OpToggle: begin
              j = sel_mask;
              k = sel_mask;
            end
            OpPulse: begin
              j            = sel_mask;
              k            = sel_mask;
              pulse_mask_d = sel_mask;
              state_d      = StPulse2;
            end
            // Illegal opcodes behave as HOLD but are flagged.
            default: err_d = 1'b1;
          endcase
        end
      end
      StPulse2: begin
        // Second toggle restores the pulsed bits.
        j       = pulse_mask_q;
        k       = pulse_mask_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Standard JK next-state equation, applied per bit.
  assign bank_d = (j & ~bank_q) | (~k & bank_q);

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      grant_q      <= 1'b0;
      acc_q        <= 16'd0;
      err_q        <= 1'b0;
      pulse_mask_q <= '0;
      bank_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      pulse_mask_q <= pulse_mask_d;
      bank_q       <= bank_d;
    end
  end

  assign req.req0_ready = ready0;
  assign req.req1_ready = ready1;
  assign q              = bank_q;
  assign q_bar          = ~bank_q;
  assign busy           = (state_q == StPulse2);
  assign grant_id       = grant_q;
  assign acc_cnt        = acc_q;
  assign err            = err_q;

endmodule
